// File: rtl/corr_window_reader.sv
// corr_window_reader
// Window sequencer and result reader for the correlator count path.
// Steps the window position (o_t) and the window-start strobe (o_zeroCounts)
// that drive the four-way correlation counter. At every window boundary it
// captures the four counts into a snapshot and presents the snapshot over a
// valid/ready handshake. A window that ends while the previous snapshot is
// still unconsumed is dropped, and the drop is counted.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_cg                  clock-gate enable (0 freezes sequencing and capture)
//   i_en                  run request
//   o_t, o_zeroCounts     window position / window start strobe to the counter
//   i_count*              counter outputs (X, Y, intersection, symmetric diff)
//   o_valid, i_ready      snapshot handshake (not gated by i_cg)
//   o_count*, o_winIdx    snapshot contents and its window sequence number
//   o_nDropped            saturating count of dropped windows
//   o_busy                sequencer is not idle
module corr_window_reader #(
  parameter int DATA_W = 16,
  parameter int TIME_W = 8,
  parameter int IDX_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cg,
  input  logic              i_en,
  output logic [TIME_W-1:0] o_t,
  output logic              o_zeroCounts,
  input  logic [DATA_W-1:0] i_countX,
  input  logic [DATA_W-1:0] i_countY,
  input  logic [DATA_W-1:0] i_countIsect,
  input  logic [DATA_W-1:0] i_countSymdiff,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_countX,
  output logic [DATA_W-1:0] o_countY,
  output logic [DATA_W-1:0] o_countIsect,
  output logic [DATA_W-1:0] o_countSymdiff,
  output logic [IDX_W-1:0]  o_winIdx,
  output logic [IDX_W-1:0]  o_nDropped,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [TIME_W-1:0] T_ZERO   = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0] T_ONE    = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_MAX  = {IDX_W{1'b1}};
  localparam logic [DATA_W-1:0] D_ZERO   = {DATA_W{1'b0}};

  state_t              state_r;
  state_t              state_next_s;
  logic [TIME_W-1:0]   t_r;
  logic [TIME_W-1:0]   t_next_s;
  logic                zero_counts_r;
  logic                busy_r;
  logic                boundary_s;
  logic                capture_s;
  logic                drop_s;
  logic                valid_r;
  logic [DATA_W-1:0]   snap_x_r;
  logic [DATA_W-1:0]   snap_y_r;
  logic [DATA_W-1:0]   snap_isect_r;
  logic [DATA_W-1:0]   snap_symdiff_r;
  logic [IDX_W-1:0]    win_idx_r;
  logic [IDX_W-1:0]    win_cnt_r;
  logic [IDX_W-1:0]    n_dropped_r;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; nothing advances while the clock gate is closed
  always_comb begin
    state_next_s = state_r;
    if (i_cg) begin
      case (state_r)
        ST_IDLE:  state_next_s = i_en ? ST_RUN : ST_IDLE;
        ST_RUN:   state_next_s = i_en ? ST_RUN : ST_DRAIN;
        // A drain finishes at its boundary cycle (o_t wrapped to 0)
        ST_DRAIN: state_next_s = (t_r == T_ZERO) ? ST_IDLE : ST_DRAIN;
        default:  state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM output logic: next window position and capture/drop decision
  always_comb begin
    boundary_s = (state_r != ST_IDLE) && (t_r == T_ZERO);
    capture_s  = 1'b0;
    drop_s     = 1'b0;
    t_next_s   = t_r;
    if (i_cg) begin
      // Leaving IDLE for RUN gives 0+1 = 1; entering IDLE parks at 0
      t_next_s  = (state_next_s == ST_IDLE) ? T_ZERO : (t_r + T_ONE);
      capture_s = boundary_s && (!valid_r || i_ready);
      drop_s    = boundary_s && valid_r && !i_ready;
    end else begin
      t_next_s  = t_r;
    end
  end

  // Window position, start strobe and busy flag, registered together so the
  // strobe always matches o_t == 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      t_r           <= T_ZERO;
      zero_counts_r <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      t_r           <= t_next_s;
      zero_counts_r <= (t_next_s == T_ZERO);
      busy_r        <= (state_next_s != ST_IDLE);
    end
  end

  // Window sequence counter and saturating drop counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_cnt_r   <= IDX_ZERO;
      n_dropped_r <= IDX_ZERO;
    end else begin
      // Every completed window consumes a sequence number, captured or not
      if (capture_s || drop_s) begin
        win_cnt_r <= win_cnt_r + IDX_ONE;
      end
      if (drop_s && (n_dropped_r != IDX_MAX)) begin
        n_dropped_r <= n_dropped_r + IDX_ONE;
      end
    end
  end

  // Snapshot register and handshake; consumption is independent of i_cg
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_r        <= 1'b0;
      snap_x_r       <= D_ZERO;
      snap_y_r       <= D_ZERO;
      snap_isect_r   <= D_ZERO;
      snap_symdiff_r <= D_ZERO;
      win_idx_r      <= IDX_ZERO;
    end else if (capture_s) begin
      valid_r        <= 1'b1;
      snap_x_r       <= i_countX;
      snap_y_r       <= i_countY;
      snap_isect_r   <= i_countIsect;
      snap_symdiff_r <= i_countSymdiff;
      win_idx_r      <= win_cnt_r;
    end else if (valid_r && i_ready) begin
      valid_r        <= 1'b0;
    end
  end

  assign o_t            = t_r;
  assign o_zeroCounts   = zero_counts_r;
  assign o_busy         = busy_r;
  assign o_valid        = valid_r;
  assign o_countX       = snap_x_r;
  assign o_countY       = snap_y_r;
  assign o_countIsect   = snap_isect_r;
  assign o_countSymdiff = snap_symdiff_r;
  assign o_winIdx       = win_idx_r;
  assign o_nDropped     = n_dropped_r;

endmodule
